// File: rtl/vm2002_change_dispenser_if.sv
// Handshake bundle between the vm2002 change dispenser, its requester, the coin ejector and
// the refill path. Coin encoding: 0 none, 1 nickel, 2 dime, 3 quarter.
interface vm2002_change_dispenser_if #(
  parameter int unsigned AMT_W = 8,
  parameter int unsigned CNT_W = 4
);
  logic             change_valid;
  logic [AMT_W-1:0] change_amount;
  logic             change_ready;
  logic             coin_out_valid;
  logic [1:0]       coin_out;
  logic             coin_out_ack;
  logic             refill_valid;
  logic [1:0]       refill_coin;
  logic [CNT_W-1:0] refill_qty;
  logic [CNT_W-1:0] quarter_count;
  logic [CNT_W-1:0] dime_count;
  logic [CNT_W-1:0] nickel_count;
  logic             done;
  logic             exact;
  logic [AMT_W-1:0] shortfall;

  modport master (
    output change_valid, change_amount, coin_out_ack, refill_valid, refill_coin, refill_qty,
    input  change_ready, coin_out_valid, coin_out, quarter_count, dime_count, nickel_count,
    input  done, exact, shortfall
  );

  modport slave (
    input  change_valid, change_amount, coin_out_ack, refill_valid, refill_coin, refill_qty,
    output change_ready, coin_out_valid, coin_out, quarter_count, dime_count, nickel_count,
    output done, exact, shortfall
  );
endinterface

// File: rtl/vm2002_change_dispenser.sv
// Greedy change payout for the vm2002 vending machine: pays quarters, dimes, then nickels one
// coin at a time over a valid/ack handshake and tracks the coin-tube inventory.
module vm2002_change_dispenser #(
  parameter int unsigned AMT_W  = 8,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned INIT_Q = 8,
  parameter int unsigned INIT_D = 8,
  parameter int unsigned INIT_N = 8
) (
  input logic                     clock,
  input logic                     reset,
  vm2002_change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSelect, StEject, StFinish} state_e;

  localparam logic [1:0] CoinNone    = 2'd0;
  localparam logic [1:0] CoinNickel  = 2'd1;
  localparam logic [1:0] CoinDime    = 2'd2;
  localparam logic [1:0] CoinQuarter = 2'd3;

  localparam logic [AMT_W-1:0] ValQ = AMT_W'(25);
  localparam logic [AMT_W-1:0] ValD = AMT_W'(10);
  localparam logic [AMT_W-1:0] ValN = AMT_W'(5);

  localparam logic [CNT_W:0] CntMax = {1'b0, {CNT_W{1'b1}}};

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       coin_q, coin_d;
  logic [CNT_W-1:0] quarter_q, quarter_d;
  logic [CNT_W-1:0] dime_q, dime_d;
  logic [CNT_W-1:0] nickel_q, nickel_d;
  logic             exact_q, exact_d;
  logic [AMT_W-1:0] shortfall_q, shortfall_d;
  logic             ack_take;

  // One extra bit so that count - ack + refill can be saturated without wrapping.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                  input logic             dec,
                                                  input logic             add_en,
                                                  input logic [CNT_W-1:0] qty);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} - {{CNT_W{1'b0}}, dec} + (add_en ? {1'b0, qty} : '0);
    return (sum > CntMax) ? CntMax[CNT_W-1:0] : sum[CNT_W-1:0];
  endfunction

  function automatic logic [AMT_W-1:0] coin_value(input logic [1:0] coin);
    logic [AMT_W-1:0] val;
    case (coin)
      CoinQuarter: val = ValQ;
      CoinDime:    val = ValD;
      CoinNickel:  val = ValN;
      default:     val = '0;
    endcase
    return val;
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    coin_d      = coin_q;
    exact_d     = exact_q;
    shortfall_d = shortfall_q;
    ack_take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.change_valid) begin
          remaining_d = bus.change_amount;
          state_d     = (bus.change_amount == '0) ? StFinish : StSelect;
        end
      end
      StSelect: begin
        // Greedy pick; a coin is only chosen if it fits, so remaining cannot underflow.
        if (remaining_q >= ValQ && quarter_q != '0) begin
          coin_d  = CoinQuarter;
          state_d = StEject;
        end else if (remaining_q >= ValD && dime_q != '0) begin
          coin_d  = CoinDime;
          state_d = StEject;
        end else if (remaining_q >= ValN && nickel_q != '0) begin
          coin_d  = CoinNickel;
          state_d = StEject;
        end else begin
          state_d = StFinish;
        end
      end
      StEject: begin
        if (bus.coin_out_ack) begin
          ack_take    = 1'b1;
          remaining_d = remaining_q - coin_value(coin_q);
          coin_d      = CoinNone;
          state_d     = StSelect;
        end
      end
      StFinish: begin
        shortfall_d = remaining_q;
        exact_d     = (remaining_q == '0);
        state_d     = StIdle;
      end
    endcase

    quarter_d = next_count(quarter_q, ack_take && (coin_q == CoinQuarter),
                           bus.refill_valid && (bus.refill_coin == CoinQuarter), bus.refill_qty);
    dime_d    = next_count(dime_q, ack_take && (coin_q == CoinDime),
                           bus.refill_valid && (bus.refill_coin == CoinDime), bus.refill_qty);
    nickel_d  = next_count(nickel_q, ack_take && (coin_q == CoinNickel),
                           bus.refill_valid && (bus.refill_coin == CoinNickel), bus.refill_qty);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      coin_q      <= CoinNone;
      quarter_q   <= CNT_W'(INIT_Q);
      dime_q      <= CNT_W'(INIT_D);
      nickel_q    <= CNT_W'(INIT_N);
      exact_q     <= 1'b0;
      shortfall_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      coin_q      <= coin_d;
      quarter_q   <= quarter_d;
      dime_q      <= dime_d;
      nickel_q    <= nickel_d;
      exact_q     <= exact_d;
      shortfall_q <= shortfall_d;
    end
  end

  assign bus.change_ready   = (state_q == StIdle);
  assign bus.coin_out_valid = (state_q == StEject);
  assign bus.coin_out       = coin_q;
  assign bus.done           = (state_q == StFinish);
  assign bus.exact          = exact_q;
  assign bus.shortfall      = shortfall_q;
  assign bus.quarter_count  = quarter_q;
  assign bus.dime_count     = dime_q;
  assign bus.nickel_count   = nickel_q;

endmodule

// File: tb/tb_vm2002_change_dispenser.sv
// Directed bench for vm2002_change_dispenser: a greedy reference model fills coin/result
// queues per request, which are popped as coins and done pulses appear.
module tb_vm2002_change_dispenser;

  localparam int unsigned AMT_W = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic [1:0] CN = 2'd1;
  localparam logic [1:0] CD = 2'd2;
  localparam logic [1:0] CQ = 2'd3;

  logic clock;
  logic reset;

  vm2002_change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  vm2002_change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .INIT_Q(8), .INIT_D(8), .INIT_N(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int mq, md, mn;
  logic [1:0] coin_exp[$];
  int short_exp[$];
  int exact_exp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_q"}, 32'(bus.quarter_count), mq);
    check({tag, "_d"}, 32'(bus.dime_count), md);
    check({tag, "_n"}, 32'(bus.nickel_count), mn);
  endtask

  task automatic refill(input logic [1:0] c, input int qty);
    @(negedge clock);
    bus.refill_valid = 1'b1;
    bus.refill_coin  = c;
    bus.refill_qty   = CNT_W'(qty);
    @(negedge clock);
    bus.refill_valid = 1'b0;
    bus.refill_coin  = 2'd0;
    bus.refill_qty   = '0;
    if (c == CQ) mq = sat(mq + qty);
    if (c == CD) md = sat(md + qty);
    if (c == CN) mn = sat(mn + qty);
    check_counts("refill");
  endtask

  // Issue one request; each coin is acked after lat cycles of valid; rq_on_ack quarters are
  // refilled in the same cycle as each ack.
  task automatic do_req(input int amt, input int lat, input int rq_on_ack);
    int rem, tq, td, tn, cyc, waitc, cnt;
    bit got_done, seen_coin;
    rem = amt; tq = mq; td = md; tn = mn;
    while (1) begin
      if (rem >= 25 && tq > 0) begin coin_exp.push_back(CQ); rem -= 25; tq--; end
      else if (rem >= 10 && td > 0) begin coin_exp.push_back(CD); rem -= 10; td--; end
      else if (rem >= 5 && tn > 0) begin coin_exp.push_back(CN); rem -= 5; tn--; end
      else break;
    end
    short_exp.push_back(rem);
    exact_exp.push_back(rem == 0 ? 1 : 0);

    @(negedge clock);
    check("ready_before_req", 32'(bus.change_ready), 1);
    bus.change_valid  = 1'b1;
    bus.change_amount = AMT_W'(amt);
    @(negedge clock);
    bus.change_valid  = 1'b0;
    bus.change_amount = '0;
    cyc = 1; waitc = 0; got_done = 0; seen_coin = 0;
    while (!got_done && cyc < 300) begin
      bus.coin_out_ack = 1'b0;
      bus.refill_valid = 1'b0;
      if (bus.coin_out_valid) begin
        if (!seen_coin) check("first_coin_latency", cyc, 2);
        seen_coin = 1;
        if (coin_exp.size() == 0) begin
          check("unexpected_coin", 32'(bus.coin_out), 0);
        end else begin
          check("coin_out", 32'(bus.coin_out), 32'(coin_exp[0]));
          case (coin_exp[0])
            CQ:      cnt = mq;
            CD:      cnt = md;
            default: cnt = mn;
          endcase
          case (bus.coin_out)
            CQ:      check("count_before_ack", 32'(bus.quarter_count), cnt);
            CD:      check("count_before_ack", 32'(bus.dime_count), cnt);
            default: check("count_before_ack", 32'(bus.nickel_count), cnt);
          endcase
          if (waitc == lat) begin
            bus.coin_out_ack = 1'b1;
            case (coin_exp[0])
              CQ:      mq--;
              CD:      md--;
              default: mn--;
            endcase
            if (rq_on_ack > 0) begin
              bus.refill_valid = 1'b1;
              bus.refill_coin  = CQ;
              bus.refill_qty   = CNT_W'(rq_on_ack);
              mq = sat(mq + rq_on_ack);
            end
            void'(coin_exp.pop_front());
            waitc = 0;
          end else begin
            waitc++;
          end
        end
      end
      if (bus.done) begin
        got_done = 1;
        if (amt == 0) check("zero_done_latency", cyc, 1);
      end
      @(negedge clock);
      cyc++;
    end
    bus.coin_out_ack = 1'b0;
    bus.refill_valid = 1'b0;
    bus.refill_coin  = 2'd0;
    bus.refill_qty   = '0;
    if (!got_done) check("done_timeout", 0, 1);
    check("done_one_cycle", 32'(bus.done), 0);
    check("coins_left", coin_exp.size(), 0);
    coin_exp.delete();
    check("shortfall", 32'(bus.shortfall), short_exp.pop_front());
    check("exact", 32'(bus.exact), exact_exp.pop_front());
    check_counts("after_req");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.change_valid = 1'b0; bus.change_amount = '0; bus.coin_out_ack = 1'b0;
    bus.refill_valid = 1'b0; bus.refill_coin = 2'd0; bus.refill_qty = '0;
    mq = 8; md = 8; mn = 8;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(bus.change_ready), 1);
    check("rst_valid", 32'(bus.coin_out_valid), 0);
    check("rst_coin", 32'(bus.coin_out), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_exact", 32'(bus.exact), 0);
    check("rst_shortfall", 32'(bus.shortfall), 0);
    check_counts("rst");

    // 1: 40 -> Q, D, N
    do_req(40, 0, 0);
    check("t1_exact", 32'(bus.exact), 1);
    check("t1_q", 32'(bus.quarter_count), 7);

    // 2: held ack keeps coin stable and count unchanged
    do_req(25, 5, 0);
    check("t2_q", 32'(bus.quarter_count), 6);

    // 3: drain dimes/nickels, then quarters to 1; 35 leaves 10 unpaid
    for (int i = 0; i < 7; i++) do_req(15, 0, 0);
    do_req(125, 1, 0);
    check("t3_drained_q", 32'(bus.quarter_count), 1);
    do_req(35, 0, 0);
    check("t3_shortfall", 32'(bus.shortfall), 10);
    check("t3_exact", 32'(bus.exact), 0);

    // 4: non-multiple of five and zero amount
    refill(CN, 1);
    do_req(7, 0, 0);
    check("t4_shortfall", 32'(bus.shortfall), 2);
    do_req(0, 0, 0);
    check("t4_zero_exact", 32'(bus.exact), 1);

    // 5: refill during ack saturates
    refill(CQ, 14);
    do_req(25, 0, 4);
    check("t5_sat_q", 32'(bus.quarter_count), 15);

    // 6: reset in EJECT aborts without done
    @(negedge clock);
    bus.change_valid = 1'b1; bus.change_amount = AMT_W'(25);
    @(negedge clock);
    bus.change_valid = 1'b0; bus.change_amount = '0;
    @(negedge clock);
    check("t6_in_eject", 32'(bus.coin_out_valid), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mq = 8; md = 8; mn = 8;
    check("t6_valid", 32'(bus.coin_out_valid), 0);
    check("t6_ready", 32'(bus.change_ready), 1);
    check("t6_exact", 32'(bus.exact), 0);
    check_counts("t6");
    for (int i = 0; i < 3; i++) begin
      check("t6_no_done", 32'(bus.done), 0);
      @(negedge clock);
    end
    do_req(65, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
